moe_tx_msg_id_mgr: RTL
======================

Name: moe_tx_msg_id_mgr

Overview:
- Transmit-side counterpart of the MOE RX FIFO status path.
- Owns the pool of 12-bit message IDs handed to outgoing messages: allocates on send, reclaims on completion/ack.
- Tracks TX data FIFO occupancy and publishes an S_MOE_TX_FIFO_ST status word to the TX scheduler and the CSR block.

Parameters:
- MSG_ID_W, 12, message-ID width.
- MSG_ID_NUM, 256, IDs in pool, values 0..MSG_ID_NUM-1; power of 2, at most 2^MSG_ID_W.
- FIFO_DEPTH, 1024, TX data FIFO depth in words; fifo_used_cnt saturates here.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  free list populated; allocation enabled.
- alloc_vld  out  1  a free ID is offered on alloc_id.
- alloc_rdy  in  1  consumer takes the offered ID.
- alloc_id  out  MSG_ID_W  offered ID.
- free_vld  in  1  return an ID to the pool (always accepted).
- free_id  in  MSG_ID_W  ID being returned.
- err_dbl_free  out  1  one-cycle pulse: returned ID was not in flight.
- fifo_push  in  1  one word written into TX data FIFO.
- fifo_pop  in  1  one word read from TX data FIFO.
- tx_fifo_st  out  48  S_MOE_TX_FIFO_ST {fifo_used_cnt, free_msg_id_cnt, inflight_msg_cnt}.

Behaviour:
- Reset values: init_done=0, alloc_vld=0, alloc_id=0, err_dbl_free=0, tx_fifo_st=0, internal pointers/counters=0, in-flight bitmap all clear.
- FSM states:
  - INIT: writes ID k into free-list RAM at cycle k after reset release, for k = 0..MSG_ID_NUM-1. free_vld/alloc_rdy ignored. Goes to LOAD after last write.
  - LOAD: one cycle; reads RAM head into alloc_id register.
  - RUN: init_done=1; stays until rst.
- rst asserted in any state (mid-INIT, mid-transfer) returns to INIT with full reinitialisation; outstanding IDs are forgotten.
- Free list: circular RAM, MSG_ID_NUM entries, rd_ptr/wr_ptr of log2(MSG_ID_NUM) bits, natural wrap. Head ID is prefetched into the alloc_id register.
- free_cnt ranges 0..MSG_ID_NUM and includes the prefetched head. alloc_vld = RUN && free_cnt != 0.
- Allocate: transfer when alloc_vld && alloc_rdy.
  - Next head is presented the following cycle.
  - Sets bitmap[alloc_id]; free_cnt-1; inflight+1.
  - alloc_id is stable while alloc_vld && !alloc_rdy.
- Free: free_vld in RUN with bitmap[free_id]=1:
  - Clears bit, writes free_id at wr_ptr, free_cnt+1, inflight-1.
  - If bitmap bit is 0 (or free_id >= MSG_ID_NUM): no state change; err_dbl_free pulses next cycle.
- Simultaneous alloc and free in the same cycle:
  - free_cnt and inflight unchanged.
  - Freeing the ID being allocated that cycle counts as a double free (bitmap is evaluated before the update).
- Empty bypass: free at cycle t while free_cnt==0 → alloc_vld=1 and alloc_id=free_id at t+1.
- fifo_used_cnt:
  - push-only +1, saturating at FIFO_DEPTH.
  - pop-only -1, saturating at 0.
  - push and pop together: unchanged.
- tx_fifo_st is registered and reflects events one cycle after they occur. Fields are zero-extended to 16 bits.
- Latency: alloc→next offer 1 cycle; free→counter update 1 cycle.

Decomposition:
- Add to shared package toe_top_define:
  - S_MOE_TX_FIFO_ST, packed {logic[15:0] fifo_used_cnt; logic[15:0] free_msg_id_cnt; logic[15:0] inflight_msg_cnt}.
  - MOE_MSG_ID_W=12.
- Sub-module moe_id_free_list: single-port-write/registered-read circular RAM plus pointers and free_cnt.
- Bitmap, FSM and FIFO counter remain in the top.

Test Plan:
- Reset release → init_done rises exactly MSG_ID_NUM+1 cycles later; alloc_vld=1, alloc_id=0, free_msg_id_cnt=256, inflight=0.
- alloc_rdy held high 256 cycles → IDs 0..255 in order, then alloc_vld=0, free_msg_id_cnt=0, inflight=256.
- Pool empty, free_id=0x07 at cycle t → alloc_vld=1 with alloc_id=0x07 at t+1; free_msg_id_cnt=1.
- Free ID 0x10 twice → second free pulses err_dbl_free once; counts unchanged. Free 0x1FF (out of range) → err_dbl_free.
- Allocate and free a different ID in the same cycle for 50 cycles → free_msg_id_cnt and inflight constant. fifo_push and fifo_pop together → fifo_used_cnt constant.
- 1030 pushes → fifo_used_cnt=1024. Then pops to zero and 3 extra pops → 0. rst asserted mid-INIT → init restarts; init_done low until 257 cycles after rst release.

Source files
------------

// File: rtl/toe_top_define.sv
// Shared TOE top-level definitions: MOE message-ID width, TX FIFO status word
// and the state encoding of the TX message-ID manager.
package toe_top_define;

    localparam int MOE_MSG_ID_W = 12;

    typedef struct packed {
        logic [15:0] fifo_used_cnt;
        logic [15:0] free_msg_id_cnt;
        logic [15:0] inflight_msg_cnt;
    } S_MOE_TX_FIFO_ST;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } id_mgr_state_e;

endpackage

// File: rtl/moe_id_free_list.sv
// Circular free list of message IDs with the head entry prefetched into a
// register; free_cnt counts every free ID including the prefetched head.
module moe_id_free_list
    import toe_top_define::*;
#(
    parameter int MSG_ID_W   = MOE_MSG_ID_W,
    parameter int MSG_ID_NUM = 256,
    localparam int IDX_W     = $clog2(MSG_ID_NUM),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_wr,
    input  logic                load,
    input  logic                alloc,
    input  logic                push,
    input  logic [MSG_ID_W-1:0] push_id,
    output logic [MSG_ID_W-1:0] head,
    output logic [CNT_W-1:0]    free_cnt
);

    logic [MSG_ID_W-1:0] ram [MSG_ID_NUM];
    logic [IDX_W-1:0]    rd_ptr;
    logic [IDX_W-1:0]    wr_ptr;
    logic                ram_has;
    logic                ram_wr;

    // RAM holds free_cnt-1 entries behind the head; when it is empty a freed
    // ID goes straight into the head register instead of through the RAM.
    assign ram_has = free_cnt > CNT_W'(1);
    assign ram_wr  = push && (alloc ? ram_has : (free_cnt != '0));

    always_ff @(posedge clk) begin
        if (init_wr) begin
            ram[wr_ptr] <= MSG_ID_W'(wr_ptr);
        end else if (ram_wr) begin
            ram[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            free_cnt <= '0;
            head     <= '0;
        end else if (init_wr) begin
            wr_ptr   <= wr_ptr + 1'b1;
            free_cnt <= free_cnt + 1'b1;
        end else if (load) begin
            head   <= ram[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
        end else begin
            case ({alloc, push})
                2'b10: begin
                    free_cnt <= free_cnt - 1'b1;
                    if (ram_has) begin
                        head   <= ram[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                2'b01: begin
                    free_cnt <= free_cnt + 1'b1;
                    if (free_cnt == '0) begin
                        head <= push_id;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                2'b11: begin
                    if (ram_has) begin
                        head   <= ram[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        wr_ptr <= wr_ptr + 1'b1;
                    end else begin
                        head <= push_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/moe_tx_msg_id_mgr.sv
// TX message-ID manager: allocates/reclaims message IDs, tracks in-flight IDs
// and TX data FIFO occupancy, and publishes the TX FIFO status word.
module moe_tx_msg_id_mgr
    import toe_top_define::*;
#(
    parameter int MSG_ID_W   = MOE_MSG_ID_W,
    parameter int MSG_ID_NUM = 256,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    output logic                alloc_vld,
    input  logic                alloc_rdy,
    output logic [MSG_ID_W-1:0] alloc_id,
    input  logic                free_vld,
    input  logic [MSG_ID_W-1:0] free_id,
    output logic                err_dbl_free,
    input  logic                fifo_push,
    input  logic                fifo_pop,
    output logic [47:0]         tx_fifo_st
);

    localparam int IDX_W  = $clog2(MSG_ID_NUM);
    localparam int CNT_W  = IDX_W + 1;
    localparam int FIFO_W = $clog2(FIFO_DEPTH + 1);

    id_mgr_state_e     state;
    id_mgr_state_e     state_nxt;
    logic              init_wr;
    logic              load;
    logic              run;
    logic              alloc;
    logic              id_in_range;
    logic              free_ok;
    logic              free_bad;
    logic [CNT_W-1:0]  free_cnt;
    logic [CNT_W-1:0]  inflight_cnt;
    logic [FIFO_W-1:0] fifo_cnt;
    logic [MSG_ID_NUM-1:0] bitmap;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  alloc_idx;
    S_MOE_TX_FIFO_ST   st;

    assign run         = (state == ST_RUN);
    assign init_done   = run;
    assign alloc_vld   = run && (free_cnt != '0);
    assign alloc       = alloc_vld && alloc_rdy;
    assign id_in_range = (free_id >> IDX_W) == '0;
    assign free_idx    = free_id[IDX_W-1:0];
    assign alloc_idx   = alloc_id[IDX_W-1:0];
    // Bitmap is read before this cycle's allocation lands, so freeing the ID
    // being handed out right now is reported as a double free.
    assign free_ok     = run && free_vld && id_in_range && bitmap[free_idx];
    assign free_bad    = run && free_vld && !free_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_wr   = 1'b0;
        load      = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr = 1'b1;
                if (free_cnt == CNT_W'(MSG_ID_NUM - 1)) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    moe_id_free_list #(
        .MSG_ID_W   (MSG_ID_W),
        .MSG_ID_NUM (MSG_ID_NUM)
    ) u_free_list (
        .clk      (clk),
        .rst      (rst),
        .init_wr  (init_wr),
        .load     (load),
        .alloc    (alloc),
        .push     (free_ok),
        .push_id  (free_id),
        .head     (alloc_id),
        .free_cnt (free_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap       <= '0;
            inflight_cnt <= '0;
            err_dbl_free <= 1'b0;
        end else begin
            if (alloc) begin
                bitmap[alloc_idx] <= 1'b1;
            end
            if (free_ok) begin
                bitmap[free_idx] <= 1'b0;
            end
            case ({alloc, free_ok})
                2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
                2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
                default: ;
            endcase
            err_dbl_free <= free_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= '0;
        end else if (fifo_push && !fifo_pop && fifo_cnt != FIFO_W'(FIFO_DEPTH)) begin
            fifo_cnt <= fifo_cnt + 1'b1;
        end else if (fifo_pop && !fifo_push && fifo_cnt != '0) begin
            fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    assign st = '{fifo_used_cnt:    16'(fifo_cnt),
                  free_msg_id_cnt:  16'(free_cnt),
                  inflight_msg_cnt: 16'(inflight_cnt)};
    assign tx_fifo_st = st;

endmodule
